spi_reg_slave: RTL

Clocked SPI mode-0 write-only slave that builds the control register bank consumed by the PWM stage.
- Samples the asynchronous SCLK/COPI/nCS pins through synchronizers in the `clk` domain.
- Deframes 16-bit transactions.
- Commits valid writes into five 8-bit registers that drive the PWM output-enable, PWM-enable and duty-cycle inputs.
- Sits between the `ui_in[2:0]` pins and the PWM generator.

---
 rtl/spi_reg_slave.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 write-only register slave: synchronizes the SPI pins into clk, deframes
// 16-bit write frames and updates the five PWM control registers.
module spi_reg_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CNT_MAX    = 17;
    localparam int unsigned NUM_REGS   = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync, fill;
    logic                   sclk_prev, ncs_prev, armed;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise_c, ncs_rise_c, ncs_fall_c;
    logic                   addr_ok_c, commit_wr_c, commit_err_c;
    logic [6:0]             addr_c;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];

    // fill marks when the ncs chain holds real pin samples; armed blocks a spurious
    // falling edge when ncs is already low as reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            fill      <= '0;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
            armed     <= armed | (fill[SYNC_STAGES-1] & ncs_s);
        end
    end

    assign sclk_rise_c = sclk_s & ~sclk_prev;
    assign ncs_rise_c  = ncs_s & ~ncs_prev;
    assign ncs_fall_c  = armed & ncs_prev & ~ncs_s;

    assign addr_c    = shift_reg[14:8];
    assign addr_ok_c = (32'(addr_c) <= MAX_ADDR) && (32'(addr_c) < NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        commit_wr_c  = 1'b0;
        commit_err_c = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall_c) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise_c) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
                if (bit_cnt != CNT_W'(FRAME_BITS)) begin
                    commit_err_c = 1'b1;
                end else if (shift_reg[15] && addr_ok_c) begin
                    commit_wr_c = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame shifter; an ncs rise in the same cycle as an sclk rise wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == IDLE && ncs_fall_c) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (state == SHIFT && sclk_rise_c && !ncs_rise_c) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
            if (bit_cnt != CNT_W'(CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= commit_wr_c;
            frame_err <= commit_err_c;
            if (commit_wr_c) begin
                case (addr_c)
                    7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
                    7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
                    7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
                    7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
                    7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
